// File: rtl/irq_pkg.sv
// Shared types and constants for the PIC interrupt responder.
package irq_pkg;

  // Responder control states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAKE,
    ST_SERVICE,
    ST_RETURN
  } state_e;

  // Cause codes above the IRQ range (0-7 carry the PIC source id directly).
  localparam logic [3:0] CAUSE_ECALL  = 4'd8;
  localparam logic [3:0] CAUSE_EBREAK = 4'd9;
  localparam logic [3:0] CAUSE_NMI    = 4'd10;

  // Vector table entries are one word apart.
  localparam int VEC_SHIFT = 2;

  // Bit positions in the pending vector handed to the arbiter.
  localparam int PEND_IRQ    = 0;
  localparam int PEND_ECALL  = 1;
  localparam int PEND_EBREAK = 2;
  localparam int PEND_NMI    = 3;

  // Vector address for a given cause.
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [3:0] c);
    return base + (32'(c) << VEC_SHIFT);
  endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Fixed-priority encoder: NMI > EBREAK > ECALL > IRQ.
module irq_arbiter
  import irq_pkg::*;
(
  input  logic [3:0] pend,
  input  logic [2:0] irq_num,
  output logic       valid,
  output logic [3:0] cause
);

  // Pick the highest-priority pending source and encode its cause.
  always_comb begin
    valid = |pend;
    cause = '0;
    if (pend[PEND_NMI])         cause = CAUSE_NMI;
    else if (pend[PEND_EBREAK]) cause = CAUSE_EBREAK;
    else if (pend[PEND_ECALL])  cause = CAUSE_ECALL;
    else if (pend[PEND_IRQ])    cause = {1'b0, irq_num};
  end

endmodule

// File: rtl/irq_responder.sv
// CPU-side responder for PIC interrupts, NMI, ECALL and EBREAK.
// Arbitrates at instruction boundaries, redirects fetch to VEC_BASE + 4*cause,
// saves the resume PC and returns to it on MRET.
// Optional build macro IRQ_NMI_NEST_EN: lets an NMI preempt an IRQ handler
// (second EPC slot, two nesting levels). Undefined: a single level only.
// The PIC request line is named int_req because "int" is a reserved word.
module irq_responder
  import irq_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_inter,
  input  logic        int_req,
  input  logic [2:0]  int_num,
  input  logic        nmi,
  input  logic        en_nmi,
  input  logic        en_ecall,
  input  logic        en_ebreak,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        instr_done,
  input  logic        mret,
  input  logic [31:0] pc_next,
  output logic        trap_take,
  output logic [31:0] trap_vec,
  output logic        ret_take,
  output logic [31:0] ret_pc,
  output logic        int_ack,
  output logic [2:0]  ack_num,
  output logic        in_handler,
  output logic [3:0]  cause,
  output logic        trap_err
);

  state_e      state_q, state_d;
  logic [3:0]  cause_d;
  logic [31:0] epc0_q, epc0_d;
  logic        nmi_prev_q, nmi_pend_q, nmi_pend_d;
  logic        nmi_rise, nmi_elig, nmi_taken;
  logic [3:0]  pend;
  logic        arb_valid;
  logic [3:0]  arb_cause;
  logic        err_d;
  logic        take_d, ret_d, ack_d, inh_d;
  logic        take_nested;
  logic [31:0] resume_pc;

  // An NMI edge seen this very cycle is eligible immediately, not a cycle later.
  assign nmi_rise = nmi & ~nmi_prev_q;
  assign nmi_elig = en_nmi & (nmi_pend_q | nmi_rise);
  assign nmi_pend_d = (nmi_pend_q | (nmi_rise & en_nmi)) & ~nmi_taken;

  assign pend[PEND_IRQ]    = int_req & en_inter;
  assign pend[PEND_ECALL]  = ecall & en_ecall;
  assign pend[PEND_EBREAK] = ebreak & en_ebreak;
  assign pend[PEND_NMI]    = nmi_elig;

  irq_arbiter u_arbiter (
    .pend    (pend),
    .irq_num (int_num),
    .valid   (arb_valid),
    .cause   (arb_cause)
  );

`ifdef IRQ_NMI_NEST_EN
  logic        nested_q, nested_d;
  logic [31:0] epc1_q, epc1_d;
  logic [3:0]  outer_q, outer_d;

  assign resume_pc   = nested_q ? epc1_q : epc0_q;
  assign take_nested = nested_d;

  // Second-level context: NMI epc and the preempted handler's cause.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nested_q <= 1'b0;
      epc1_q   <= '0;
      outer_q  <= '0;
    end else begin
      nested_q <= nested_d;
      epc1_q   <= epc1_d;
      outer_q  <= outer_d;
    end
  end
`else
  assign resume_pc   = epc0_q;
  assign take_nested = 1'b0;
`endif

  // Next-state and context update.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause;
    epc0_d    = epc0_q;
    nmi_taken = 1'b0;
    err_d     = 1'b0;
`ifdef IRQ_NMI_NEST_EN
    nested_d  = nested_q;
    epc1_d    = epc1_q;
    outer_d   = outer_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (instr_done && arb_valid) begin
          state_d   = ST_TAKE;
          cause_d   = arb_cause;
          epc0_d    = pc_next;
          nmi_taken = (arb_cause == CAUSE_NMI);
        end
      end
      ST_TAKE: state_d = ST_SERVICE;
      ST_SERVICE: begin
        // Synchronous exceptions cannot be taken inside a handler.
        err_d = instr_done & (pend[PEND_ECALL] | pend[PEND_EBREAK]);
        if (instr_done && mret) begin
          state_d = ST_RETURN;
        end
`ifdef IRQ_NMI_NEST_EN
        else if (instr_done && nmi_elig && !nested_q && !cause[3]) begin
          state_d   = ST_TAKE;
          outer_d   = cause;
          cause_d   = CAUSE_NMI;
          epc1_d    = pc_next;
          nested_d  = 1'b1;
          nmi_taken = 1'b1;
        end
`endif
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
`ifdef IRQ_NMI_NEST_EN
        if (nested_q) begin
          state_d  = ST_SERVICE;
          cause_d  = outer_q;
          nested_d = 1'b0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output strobes are decoded from the next state so they register in
  // the same edge that enters TAKE or RETURN.
  assign take_d = (state_d == ST_TAKE);
  assign ret_d  = (state_d == ST_RETURN);
  assign ack_d  = take_d & ~cause_d[3];
  assign inh_d  = (state_d == ST_SERVICE) | ret_d | (take_d & take_nested);

  // State and first-level context registers.
  // NOTE: sequential state uses non-blocking assignments only; every flop,
  // context included, has a defined reset value since reset may land mid-trap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cause      <= '0;
      epc0_q     <= '0;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause      <= cause_d;
      epc0_q     <= epc0_d;
      nmi_prev_q <= nmi;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  // Registered outputs; data fields are zero outside their strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_take  <= 1'b0;
      trap_vec   <= '0;
      ret_take   <= 1'b0;
      ret_pc     <= '0;
      int_ack    <= 1'b0;
      ack_num    <= '0;
      in_handler <= 1'b0;
      trap_err   <= 1'b0;
    end else begin
      trap_take  <= take_d;
      trap_vec   <= take_d ? vec_addr(VEC_BASE, cause_d) : '0;
      ret_take   <= ret_d;
      ret_pc     <= ret_d ? resume_pc : '0;
      int_ack    <= ack_d;
      ack_num    <= ack_d ? cause_d[2:0] : '0;
      in_handler <= inh_d;
      trap_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_irq_responder.sv
// Self-checking bench for irq_responder: directed scenarios followed by
// randomized traffic, all compared against a handler-stack reference model.
// Honours IRQ_NMI_NEST_EN when defined.
module tb_irq_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_inter, int_req, nmi, en_nmi, en_ecall, en_ebreak;
  logic        ecall, ebreak, instr_done, mret;
  logic [2:0]  int_num;
  logic [31:0] pc_next;
  logic        trap_take, ret_take, int_ack, in_handler, trap_err;
  logic [31:0] trap_vec, ret_pc;
  logic [2:0]  ack_num;
  logic [3:0]  cause;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef IRQ_NMI_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  irq_responder dut (
    .clk        (clk),
    .rst        (rst),
    .en_inter   (en_inter),
    .int_req    (int_req),
    .int_num    (int_num),
    .nmi        (nmi),
    .en_nmi     (en_nmi),
    .en_ecall   (en_ecall),
    .en_ebreak  (en_ebreak),
    .ecall      (ecall),
    .ebreak     (ebreak),
    .instr_done (instr_done),
    .mret       (mret),
    .pc_next    (pc_next),
    .trap_take  (trap_take),
    .trap_vec   (trap_vec),
    .ret_take   (ret_take),
    .ret_pc     (ret_pc),
    .int_ack    (int_ack),
    .ack_num    (ack_num),
    .in_handler (in_handler),
    .cause      (cause),
    .trap_err   (trap_err)
  );

  always #5 clk = ~clk;

  // Reference model: a stack of active handler frames plus expected outputs.
  typedef struct {
    logic [3:0]  c;
    logic [31:0] epc;
  } frame_t;

  frame_t      stk[$];
  bit          m_take, m_ret, m_ack, m_err, m_inh;
  logic [31:0] m_vec, m_rpc;
  logic [2:0]  m_anum;
  logic [3:0]  m_cause;
  bit          m_nmi_prev, m_nmi_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_take = 0; m_ret = 0; m_ack = 0; m_err = 0; m_inh = 0;
    m_vec = '0; m_rpc = '0; m_anum = '0; m_cause = '0;
    m_nmi_prev = 0; m_nmi_pend = 0;
  endtask

  task automatic model_push(input logic [3:0] c);
    stk.push_back('{c: c, epc: pc_next});
    m_take  = 1;
    m_vec   = 32'h100 + 32'(c) * 4;
    m_cause = c;
    if (c < 8) begin
      m_ack  = 1;
      m_anum = c[2:0];
    end
    if (c == 4'd10) m_nmi_pend = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT samples now.
  task automatic model_step();
    bit was_take = m_take;
    bit was_ret  = m_ret;
    bit nmi_ok, found;
    logic [3:0] pick;
    m_take = 0; m_ret = 0; m_ack = 0; m_err = 0;
    m_vec = '0; m_rpc = '0; m_anum = '0;
    if (nmi && !m_nmi_prev && en_nmi) m_nmi_pend = 1;
    m_nmi_prev = nmi;
    nmi_ok = en_nmi && m_nmi_pend;
    if (was_take) begin
      m_inh = 1;
    end else if (was_ret) begin
      void'(stk.pop_back());
      m_inh = (stk.size() != 0);
      if (m_inh) m_cause = stk[$].c;
    end else if (stk.size() == 0) begin
      if (instr_done) begin
        found = 1;
        pick  = '0;
        if (nmi_ok)                    pick = 4'd10;
        else if (ebreak && en_ebreak)  pick = 4'd9;
        else if (ecall && en_ecall)    pick = 4'd8;
        else if (int_req && en_inter)  pick = {1'b0, int_num};
        else                           found = 0;
        if (found) model_push(pick);
      end
    end else if (instr_done) begin
      if ((ecall && en_ecall) || (ebreak && en_ebreak)) m_err = 1;
      if (mret) begin
        m_ret = 1;
        m_rpc = stk[$].epc;
      end else if (NEST && stk.size() == 1 && stk[$].c < 8 && nmi_ok) begin
        model_push(4'd10);
        m_inh = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("trap_take",  32'(trap_take),  32'(m_take));
    check("ret_take",   32'(ret_take),   32'(m_ret));
    check("int_ack",    32'(int_ack),    32'(m_ack));
    check("in_handler", 32'(in_handler), 32'(m_inh));
    check("trap_err",   32'(trap_err),   32'(m_err));
    check("cause",      32'(cause),      32'(m_cause));
    if (m_take) check("trap_vec", trap_vec, m_vec);
    if (m_ack)  check("ack_num",  32'(ack_num), 32'(m_anum));
    if (m_ret)  check("ret_pc",   ret_pc, m_rpc);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic quiet();
    instr_done = 0; ecall = 0; ebreak = 0; mret = 0;
  endtask

  task automatic do_mret();
    instr_done = 1; mret = 1;
    step();
    quiet();
  endtask

  task automatic rand_drive();
    int r;
    quiet();
    instr_done = ($urandom_range(0, 1) == 1);
    pc_next    = $urandom() & 32'hffff_fffc;
    if (instr_done) begin
      r = $urandom_range(0, 9);
      if (r == 0)      ecall  = 1;
      else if (r == 1) ebreak = 1;
      else if (r <= 3) mret   = 1;
    end
    if ($urandom_range(0, 15) == 0) nmi = ~nmi;
    if ($urandom_range(0, 29) == 0) en_inter = ~en_inter;
    en_ecall  = ($urandom_range(0, 3) != 0);
    en_ebreak = ($urandom_range(0, 3) != 0);
    en_nmi    = ($urandom_range(0, 15) != 0);
    // PIC holds its request until the ack, then drops it.
    if (int_req && m_ack) int_req = 0;
    else if (!int_req && $urandom_range(0, 5) == 0) begin
      int_req = 1;
      int_num = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    rst = 0;
    en_inter = 1; int_req = 0; int_num = '0; nmi = 0; en_nmi = 1;
    en_ecall = 1; en_ebreak = 1; pc_next = '0;
    quiet();
    model_reset();
    repeat (2) step();
    check("reset_in_handler", 32'(in_handler), 32'd0);
    rst = 1;
    step();

    // IRQ 5 at pc 0x40, later MRET back to 0x40.
    int_req = 1; int_num = 3'd5; instr_done = 1; pc_next = 32'h40;
    step();
    check("irq5_vec", trap_vec, 32'h114);
    check("irq5_ack_num", 32'(ack_num), 32'd5);
    quiet(); int_req = 0;
    step();
    check("irq5_in_handler", 32'(in_handler), 32'd1);
    repeat (3) step();
    do_mret();
    check("irq5_ret_pc", ret_pc, 32'h40);
    step();
    check("irq5_done", 32'(in_handler), 32'd0);

    // NMI and IRQ 2 together: NMI wins, IRQ follows after return.
    nmi = 1; int_req = 1; int_num = 3'd2; instr_done = 1; pc_next = 32'h300;
    step();
    check("nmi_cause", 32'(cause), 32'd10);
    check("nmi_vec", trap_vec, 32'h128);
    quiet();
    repeat (2) step();
    do_mret();
    step();
    instr_done = 1; pc_next = 32'h304;
    step();
    check("irq2_after_nmi", 32'(trap_take), 32'd1);
    check("irq2_cause", 32'(cause), 32'd2);
    quiet(); int_req = 0; nmi = 0;
    step();
    do_mret();
    step();

    // Masked IRQ for 20 cycles.
    en_inter = 0; int_req = 1; int_num = 3'd6;
    for (int i = 0; i < 20; i++) begin
      instr_done = i[0];
      step();
      check("masked_take", 32'(trap_take), 32'd0);
      check("masked_ack", 32'(int_ack), 32'd0);
    end
    quiet(); int_req = 0; en_inter = 1;

    // ECALL enters a handler; a second ECALL inside it only flags trap_err.
    instr_done = 1; ecall = 1; pc_next = 32'h500;
    step();
    check("ecall_vec", trap_vec, 32'h120);
    quiet();
    step();
    instr_done = 1; ecall = 1;
    step();
    check("ecall_err", 32'(trap_err), 32'd1);
    quiet();
    step();
    check("ecall_err_clear", 32'(trap_err), 32'd0);
    check("ecall_still_in", 32'(in_handler), 32'd1);
    do_mret();
    step();

    // Reset asserted in the middle of TAKE.
    int_req = 1; int_num = 3'd1; instr_done = 1; pc_next = 32'h600;
    step();
    check("pre_reset_take", 32'(trap_take), 32'd1);
    #1 rst = 0;
    #1;
    model_reset();
    check("rst_trap_take", 32'(trap_take), 32'd0);
    check("rst_trap_vec", trap_vec, 32'd0);
    check("rst_int_ack", 32'(int_ack), 32'd0);
    check("rst_ack_num", 32'(ack_num), 32'd0);
    check("rst_in_handler", 32'(in_handler), 32'd0);
    check("rst_cause", 32'(cause), 32'd0);
    check("rst_ret_take", 32'(ret_take), 32'd0);
    check("rst_ret_pc", ret_pc, 32'd0);
    check("rst_trap_err", 32'(trap_err), 32'd0);
    quiet(); int_req = 0;
    step();
    rst = 1;
    step();
    instr_done = 1; ebreak = 1; pc_next = 32'h700;
    step();
    check("post_reset_ebreak_vec", trap_vec, 32'h124);
    quiet();
    step();
    do_mret();
    check("post_reset_ret_pc", ret_pc, 32'h700);
    step();

`ifdef IRQ_NMI_NEST_EN
    // IRQ 3 handler preempted by NMI, then unwound level by level.
    int_req = 1; int_num = 3'd3; instr_done = 1; pc_next = 32'h80;
    step();
    quiet(); int_req = 0;
    step();
    nmi = 1; instr_done = 1; pc_next = 32'h200;
    step();
    check("nest_vec", trap_vec, 32'h128);
    check("nest_in_handler", 32'(in_handler), 32'd1);
    quiet();
    step();
    do_mret();
    check("nest_ret1", ret_pc, 32'h200);
    step();
    check("nest_outer_cause", 32'(cause), 32'd3);
    do_mret();
    check("nest_ret2", ret_pc, 32'h80);
    step();
    nmi = 0;
    step();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_responder.md
# irq_responder

CPU-side responder for the PIC interrupt interface inside the RISCV core. It takes the PIC's `int`/`int_num` request, plus NMI, ECALL and EBREAK events. At an instruction boundary it arbitrates them, acknowledges the PIC, and redirects fetch to a per-cause vector after saving the resume PC. It then returns to the saved PC when the handler executes MRET.

## Interface
- `VEC_BASE`, 32'h0000_0100: base of the vector table; entry = VEC_BASE + 4*cause.
- `clk` in 1: core clock.
- `rst` in 1: reset, asynchronous, active-low.
- `en_inter` in 1: global maskable-interrupt enable.
- `int` in 1: PIC request (level, held until acked).
- `int_num` in 3: PIC source id, valid with `int`.
- `nmi` in 1: non-maskable request (level; rising edge latched).
- `en_nmi`, `en_ecall`, `en_ebreak` in 1 each: per-source enables.
- `ecall`, `ebreak` in 1: single-cycle pulses from decode, qualified by `instr_done`.
- `instr_done` in 1: current instruction retires this cycle (safe point).
- `mret` in 1: MRET retiring (qualified by `instr_done`).
- `pc_next` in 32: resume address for the retiring instruction.
- `trap_take` out 1: one-cycle fetch redirect to `trap_vec`.
- `trap_vec` out 32: vector address.
- `ret_take` out 1: one-cycle fetch redirect to `ret_pc`.
- `ret_pc` out 32: saved EPC.
- `int_ack` out 1, `ack_num` out 3: one-cycle PIC acknowledge and the acked id.
- `in_handler` out 1: handler active, lower-priority sources masked.
- `cause` out 4: latched cause.
- `trap_err` out 1: one-cycle pulse when ECALL/EBREAK is dropped inside a handler.

## Operation
- Cause codes: 0–7 = IRQ `int_num`; 8 = ECALL; 9 = EBREAK; 10 = NMI.
- Priority: NMI > EBREAK > ECALL > IRQ.
- NMI pending latch:
  - Set on a `nmi` rising edge when `en_nmi` = 1.
  - Cleared when the NMI is taken.
- FSM states: IDLE, TAKE, SERVICE, RETURN.
- IDLE:
  - Sampling happens only when `instr_done` = 1.
  - If any enabled event is pending, latch `cause`, set epc <= `pc_next`, go to TAKE.
  - IRQ is eligible only if `en_inter` = 1.
- TAKE (1 cycle):
  - `trap_take` = 1, `trap_vec` = VEC_BASE + {cause, 2'b00}.
  - If cause < 8: `int_ack` = 1 and `ack_num` = latched id.
  - Next state: SERVICE.
- SERVICE:
  - `in_handler` = 1 and IRQ is masked.
  - `mret` with `instr_done` moves to RETURN.
  - ECALL/EBREAK are dropped and pulse `trap_err`.
  - NMI stays pending until return, unless NMI_NEST_EN is defined.
- RETURN (1 cycle):
  - `ret_take` = 1, `ret_pc` = epc.
  - Next state: IDLE, or SERVICE of the outer level when nested.
- Simultaneous events:
  - Same-cycle events resolve by priority.
  - A losing level IRQ stays pending.
  - A losing ECALL/EBREAK pulse is lost; decode guarantees exclusivity.
  - `mret` together with a new event: `mret` wins.
- Reset (asserted at any time, including mid-TAKE or mid-RETURN):
  - State goes to IDLE.
  - All outputs, epc, cause and the NMI latch clear to 0.

## Timing
- Event sampled at edge N (IDLE, `instr_done`=1) → `trap_take`/`int_ack` high during cycle N+1 → `in_handler` high from N+2.
- `mret` sampled at edge M → `ret_take` high during M+1 → `in_handler` low from M+2 (non-nested).
- All outputs are registered; pulses last exactly one cycle.
- PIC must drop or change `int` no earlier than the cycle after `int_ack`.

## Configuration
- `IRQ_NMI_NEST_EN` defined:
  - An NMI in SERVICE with cause < 8 preempts the handler.
  - Flow: second epc slot <= `pc_next`, TAKE with cause 10.
  - Its MRET returns to the outer handler; SERVICE and cause are restored.
  - Maximum nesting depth is 2.
- Undefined:
  - One epc slot only.
  - An NMI in SERVICE waits for RETURN and is taken at the next IDLE `instr_done`.

## Structure
- Package `irq_pkg`:
  - State enum.
  - Cause constants (CAUSE_ECALL = 8, CAUSE_EBREAK = 9, CAUSE_NMI = 10).
  - Vector shift (2).
- Sub-module `irq_arbiter`: combinational priority encoder (pending vector → valid, cause).

## Test plan
- `int`=1, `int_num`=5, `en_inter`=1, `instr_done` pulse with `pc_next`=0x40:
  - `trap_take` with `trap_vec`=0x114; `int_ack` with `ack_num`=5.
  - MRET later → `ret_pc`=0x40.
- `nmi` and `int` (num 2) rise together at `instr_done`:
  - `cause`=10, `trap_vec`=0x128.
  - The IRQ is taken at the first IDLE `instr_done` after return.
- `en_inter`=0 with `int`=1 for 20 cycles: no `trap_take`, no `int_ack`.
- `ecall` pulse inside SERVICE: `trap_err`=1 for one cycle; state is unchanged.
- Reset asserted during TAKE: all outputs are 0 in the same cycle; IDLE after release.
- With `IRQ_NMI_NEST_EN`:
  - IRQ 3 handler at epc 0x80, then NMI at `pc_next`=0x200 → vector 0x128.
  - First MRET → `ret_pc`=0x200; second MRET → 0x80.
